ksa15_multiword_adder: RTL

Sequential front-end that streams multi-word operands, 15 bits per word and least-significant word first, through a combinational 15-bit Kogge-Stone adder core with carry-in. It keeps the inter-word carry in a register and returns one registered sum word per input word, with the final carry-out on the last word. It sits directly upstream of the 15-bit KS adder and is the only driver of the adder's carry-in, so wide additions run at one word per cycle.

---
 rtl/ksa15_pkg.sv | 20 ++
 rtl/ksa15_core.sv | 69 ++++++
 rtl/ksa15_multiword_adder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ksa15_pkg.sv
// Shared definitions for the 15-bit Kogge-Stone multi-word adder front-end.
package ksa15_pkg;

    localparam int unsigned DEF_WORD_W = 15;
    localparam int unsigned DEF_IDX_W  = 8;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;

    // One registered output beat.
    typedef struct packed {
        logic [DEF_WORD_W-1:0] sum;
        logic                  last;
        logic                  cout;
        logic [DEF_IDX_W-1:0]  idx;
    } out_beat_t;

endpackage

// File: rtl/ksa15_core.sv
// 15-bit Kogge-Stone adder with carry-in: s[15:0] = x + y + cin.
// The carry-in is folded into the bit-0 generate term, so the four prefix
// levels (spans 1, 2, 4, 8) directly yield every bit's carry-in.
module ksa15_core (
    input  logic [14:0] x,
    input  logic [14:0] y,
    input  logic        cin,
    output logic [15:0] s
);

    logic [14:0] p0, g0;
    logic [14:0] p1, g1;
    logic [14:0] p2, g2;
    logic [14:8] p3;
    logic [14:0] g3;
    logic [14:0] g4;

    // Bit-level generate/propagate with carry-in merged into bit 0
    always_comb begin
        p0    = x ^ y;
        g0    = x & y;
        g0[0] = g0[0] | (p0[0] & cin);
    end

    // Prefix level, span 1
    always_comb begin
        g1 = g0;
        p1 = p0;
        for (int i = 1; i < 15; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end
    end

    // Prefix level, span 2
    always_comb begin
        g2 = g1;
        p2 = p1;
        for (int i = 2; i < 15; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end
    end

    // Prefix level, span 4; only the upper propagates feed the last level
    always_comb begin
        g3 = g2;
        for (int i = 4; i < 15; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
        end
        for (int i = 8; i < 15; i++) begin
            p3[i] = p2[i] & p2[i-4];
        end
    end

    // Prefix level, span 8; g4[i] is the carry out of bit i
    always_comb begin
        g4 = g3;
        for (int i = 8; i < 15; i++) begin
            g4[i] = g3[i] | (p3[i] & g3[i-8]);
        end
    end

    // Sum bits and final carry-out
    always_comb begin
        s = {g4[14], p0 ^ {g4[13:0], cin}};
    end

endmodule

// File: rtl/ksa15_multiword_adder.sv
// Streams multi-word operands (15-bit words, LSW first) through ksa15_core,
// carrying between words in carry_q; one registered result per input word.
// Optional feature macro: KSA_SUB_EN adds in_sub and per-operand subtraction.
// WORD_W and IDX_W must match the package defaults (out_beat_t is sized by them).
module ksa15_multiword_adder
    import ksa15_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_x,
    input  logic [WORD_W-1:0] in_y,
    input  logic              in_first,
    input  logic              in_last,
`ifdef KSA_SUB_EN
    input  logic              in_sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic [IDX_W-1:0]  out_idx,
    output logic              seq_err
);

    state_t            state_q, state_d;
    logic              carry_q;
    logic              seq_err_q;
    logic              out_valid_q;
    out_beat_t         out_q, beat_d;
    logic              accept, is_first, frame_err;
    logic [WORD_W-1:0] y_eff;
    logic              init_c, cin;
    logic [15:0]       sum_full;
    logic [IDX_W-1:0]  idx_d;
`ifdef KSA_SUB_EN
    logic              sub_q;
    logic              sub_eff;
`endif

    // Ready is forced low in reset; otherwise full-throughput single-stage pipeline
    assign in_ready = rst_n & (~out_valid_q | out_ready);

    // Handshake and framing classification; a beat in IDLE always starts an operand
    always_comb begin
        accept    = in_valid & in_ready;
        is_first  = in_first | (state_q == IDLE);
        frame_err = in_first ? (state_q == RUN) : (state_q == IDLE);
    end

`ifdef KSA_SUB_EN
    // Subtract mode comes from in_sub on a first beat, from the latch afterwards
    always_comb begin
        sub_eff = is_first ? in_sub : sub_q;
        y_eff   = sub_eff ? ~in_y : in_y;
        init_c  = sub_eff;
    end
`else
    // Add-only build: operand Y passes straight through, initial carry is zero
    always_comb begin
        y_eff  = in_y;
        init_c = 1'b0;
    end
`endif

    // Carry-in select: fresh operand restarts the chain, otherwise chain the carry
    always_comb begin
        cin = is_first ? init_c : carry_q;
    end

    ksa15_core u_core (
        .x   (in_x),
        .y   (y_eff),
        .cin (cin),
        .s   (sum_full)
    );

    // Word index: restart on first beat, else increment and saturate
    always_comb begin
        if (is_first) begin
            idx_d = '0;
        end else if (out_q.idx == '1) begin
            idx_d = out_q.idx;
        end else begin
            idx_d = out_q.idx + IDX_W'(1);
        end
    end

    // Assemble the next output beat
    always_comb begin
        beat_d      = '0;
        beat_d.sum  = sum_full[14:0];
        beat_d.last = in_last;
        beat_d.cout = in_last & sum_full[15];
        beat_d.idx  = idx_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = in_last ? IDLE : RUN;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Inter-word carry, subtract latch and sticky framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q   <= 1'b0;
            seq_err_q <= 1'b0;
`ifdef KSA_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else if (accept) begin
            carry_q <= sum_full[15];
            if (frame_err) begin
                seq_err_q <= 1'b1;
            end
`ifdef KSA_SUB_EN
            if (is_first) begin
                sub_q <= in_sub;
            end
`endif
        end
    end

    // Output register: load on accept, drop valid when drained, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= beat_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_q.sum;
    assign out_last  = out_q.last;
    assign out_cout  = out_q.cout;
    assign out_idx   = out_q.idx;
    assign seq_err   = seq_err_q;

endmodule
